// File: rtl/mips_pkg.sv
// Shared pipeline definitions: operand forwarding selects and hazard FSM states.
package mips_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;

   typedef enum logic [0:0] {
      StIdle,
      StStall1
   } hazard_state_e;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand source select for one EX-stage operand.
module forwarding_unit
   import mips_pkg::*;
(
   input  logic [4:0] addr_ex,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_dest,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_dest,
   output logic [1:0] fwd_sel
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = mem_reg_write && (mem_dest == addr_ex) && (addr_ex != 5'd0);
      wb_hit  = wb_reg_write && (wb_dest == addr_ex) && (addr_ex != 5'd0);
      // The younger MEM result wins over the older WB result for the same register.
      if (mem_hit) begin
         fwd_sel = FWD_MEM;
      end else if (wb_hit) begin
         fwd_sel = FWD_WB;
      end else begin
         fwd_sel = FWD_REGFILE;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection (load-use and branch-compare stalls) plus EX operand forwarding.
module hazard_unit
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  addressRsId,
   input  logic [4:0]  addressRtId,
   input  logic        branchId,
   input  logic [4:0]  addressRsEx,
   input  logic [4:0]  addressRtEx,
   input  logic        memReadEx,
   input  logic        regWriteEx,
   input  logic [4:0]  regWriteRegisterEx,
   input  logic        memReadMemInput,
   input  logic        regWriteMemInput,
   input  logic [4:0]  regWriteRegisterMemInput,
   input  logic        regWriteWbInput,
   input  logic [4:0]  regWriteAddressWbInput,
   output logic        hazard,
   output logic [1:0]  forwardingMux0Ex,
   output logic [1:0]  forwardingMux1Ex,
   output logic [31:0] stallCount
);

   hazard_state_e state_q, state_d;
   logic [31:0]   stall_count_q;
   logic [1:0]    stall_len;
   logic          dep_ex;
   logic          dep_mem;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;

   forwarding_unit u_fwd_a (
      .addr_ex       (addressRsEx),
      .mem_reg_write (regWriteMemInput),
      .mem_dest      (regWriteRegisterMemInput),
      .wb_reg_write  (regWriteWbInput),
      .wb_dest       (regWriteAddressWbInput),
      .fwd_sel       (fwd_a)
   );

   forwarding_unit u_fwd_b (
      .addr_ex       (addressRtEx),
      .mem_reg_write (regWriteMemInput),
      .mem_dest      (regWriteRegisterMemInput),
      .wb_reg_write  (regWriteWbInput),
      .wb_dest       (regWriteAddressWbInput),
      .fwd_sel       (fwd_b)
   );

   always_comb begin
      forwardingMux0Ex = reset ? FWD_REGFILE : fwd_a;
      forwardingMux1Ex = reset ? FWD_REGFILE : fwd_b;
   end

   always_comb begin
      dep_ex  = regWriteEx && (regWriteRegisterEx != 5'd0) &&
                ((regWriteRegisterEx == addressRsId) || (regWriteRegisterEx == addressRtId));
      dep_mem = regWriteMemInput && (regWriteRegisterMemInput != 5'd0) &&
                ((regWriteRegisterMemInput == addressRsId) ||
                 (regWriteRegisterMemInput == addressRtId));
      // A branch waiting on a load in EX needs the data two stages later, hence two bubbles.
      if (branchId && memReadEx && dep_ex) begin
         stall_len = 2'd2;
      end else if (memReadEx && dep_ex) begin
         stall_len = 2'd1;
      end else if (branchId && dep_ex) begin
         stall_len = 2'd1;
      end else if (branchId && memReadMemInput && dep_mem) begin
         stall_len = 2'd1;
      end else begin
         stall_len = 2'd0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   state_d = (stall_len == 2'd2) ? StStall1 : StIdle;
         StStall1: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      hazard = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StIdle:   hazard = (stall_len != 2'd0);
            StStall1: hazard = 1'b1;
            default:  hazard = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= 32'd0;
      end else if (hazard && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a rule-level reference model.
module tb_hazard_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  addressRsId, addressRtId, addressRsEx, addressRtEx;
   logic        branchId, memReadEx, regWriteEx, memReadMemInput, regWriteMemInput;
   logic        regWriteWbInput;
   logic [4:0]  regWriteRegisterEx, regWriteRegisterMemInput, regWriteAddressWbInput;
   logic        hazard;
   logic [1:0]  forwardingMux0Ex, forwardingMux1Ex;
   logic [31:0] stallCount;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining forced stall cycles and a saturating counter.
   int          m_pending;
   longint      m_count;

   hazard_unit dut (
      .clk                      (clk),
      .reset                    (reset),
      .addressRsId              (addressRsId),
      .addressRtId              (addressRtId),
      .branchId                 (branchId),
      .addressRsEx              (addressRsEx),
      .addressRtEx              (addressRtEx),
      .memReadEx                (memReadEx),
      .regWriteEx               (regWriteEx),
      .regWriteRegisterEx       (regWriteRegisterEx),
      .memReadMemInput          (memReadMemInput),
      .regWriteMemInput         (regWriteMemInput),
      .regWriteRegisterMemInput (regWriteRegisterMemInput),
      .regWriteWbInput          (regWriteWbInput),
      .regWriteAddressWbInput   (regWriteAddressWbInput),
      .hazard                   (hazard),
      .forwardingMux0Ex         (forwardingMux0Ex),
      .forwardingMux1Ex         (forwardingMux1Ex),
      .stallCount               (stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit dep(input bit wr, input logic [4:0] r);
      return wr && (r != 5'd0) && ((r == addressRsId) || (r == addressRtId));
   endfunction

   function automatic int calc_len();
      bit de = dep(regWriteEx, regWriteRegisterEx);
      bit dm = dep(regWriteMemInput, regWriteRegisterMemInput);
      if (branchId && memReadEx && de) return 2;
      if (memReadEx && de) return 1;
      if (branchId && de) return 1;
      if (branchId && memReadMemInput && dm) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] calc_fwd(input logic [4:0] r);
      if (reset) return 2'b00;
      if (regWriteMemInput && regWriteRegisterMemInput == r && r != 5'd0) return 2'b10;
      if (regWriteWbInput && regWriteAddressWbInput == r && r != 5'd0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_hazard();
      if (reset) return 1'b0;
      return (m_pending > 0) || (calc_len() != 0);
   endfunction

   // Advance one clock; the model sees the same inputs the DUT sampled.
   task automatic cycle();
      logic h;
      @(posedge clk);
      h = exp_hazard();
      if (reset) begin
         m_pending = 0;
         m_count   = 0;
      end else begin
         if (h && m_count != 64'h0000_0000_FFFF_FFFF) m_count++;
         if (m_pending > 0) m_pending--;
         else if (calc_len() == 2) m_pending = 1;
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      {addressRsId, addressRtId, addressRsEx, addressRtEx} = '0;
      {branchId, memReadEx, regWriteEx, memReadMemInput, regWriteMemInput} = '0;
      regWriteWbInput = 1'b0;
      {regWriteRegisterEx, regWriteRegisterMemInput, regWriteAddressWbInput} = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic set_load_use();
      memReadEx = 1'b1; regWriteEx = 1'b1; regWriteRegisterEx = 5'd2;
      addressRsId = 5'd2; addressRtId = 5'd4;
   endtask

   task automatic set_branch_load();
      memReadEx = 1'b1; regWriteEx = 1'b1; regWriteRegisterEx = 5'd5;
      branchId = 1'b1; addressRsId = 5'd5; addressRtId = 5'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_load_use();
      regWriteMemInput = 1'b1; regWriteRegisterMemInput = 5'd3; addressRsEx = 5'd3;
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL reset_hazard got %b want 0", hazard);
      end
      checks++;
      if (forwardingMux0Ex !== 2'b00) begin
         errors++; $display("FAIL reset_fwd0 got %b want 00", forwardingMux0Ex);
      end
      cycle();
      checks++;
      if (stallCount !== 32'd0) begin
         errors++; $display("FAIL reset_count got %h want 0", stallCount);
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         errors++; $display("FAIL load_use_hazard got %b want 1", hazard);
      end
      cycle();
      clear_inputs();
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL load_use_release got %b want 0", hazard);
      end
      checks++;
      if (stallCount !== 32'd1) begin
         errors++; $display("FAIL load_use_count got %h want 1", stallCount);
      end
   endtask

   task automatic test_branch_load();
      do_reset();
      set_branch_load();
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         errors++; $display("FAIL branch_load_c1 got %b want 1", hazard);
      end
      cycle();
      clear_inputs();
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         errors++; $display("FAIL branch_load_c2 got %b want 1", hazard);
      end
      cycle();
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL branch_load_c3 got %b want 0", hazard);
      end
      checks++;
      if (stallCount !== 32'd2) begin
         errors++; $display("FAIL branch_load_count got %h want 2", stallCount);
      end
   endtask

   task automatic test_forward_priority();
      clear_inputs();
      regWriteMemInput = 1'b1; regWriteRegisterMemInput = 5'd7;
      regWriteWbInput = 1'b1; regWriteAddressWbInput = 5'd7;
      addressRsEx = 5'd7; addressRtEx = 5'd7;
      #1;
      checks++;
      if (forwardingMux0Ex !== 2'b10) begin
         errors++; $display("FAIL fwd_mem_priority got %b want 10", forwardingMux0Ex);
      end
      regWriteMemInput = 1'b0;
      #1;
      checks++;
      if (forwardingMux0Ex !== 2'b01) begin
         errors++; $display("FAIL fwd_wb_a got %b want 01", forwardingMux0Ex);
      end
      checks++;
      if (forwardingMux1Ex !== 2'b01) begin
         errors++; $display("FAIL fwd_wb_b got %b want 01", forwardingMux1Ex);
      end
      clear_inputs();
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      memReadEx = 1'b1; regWriteEx = 1'b1; regWriteRegisterEx = 5'd0; addressRsId = 5'd0;
      regWriteMemInput = 1'b1; regWriteRegisterMemInput = 5'd0; addressRtEx = 5'd0;
      regWriteWbInput = 1'b1; regWriteAddressWbInput = 5'd0;
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL zero_reg_hazard got %b want 0", hazard);
      end
      checks++;
      if (forwardingMux1Ex !== 2'b00) begin
         errors++; $display("FAIL zero_reg_fwd1 got %b want 00", forwardingMux1Ex);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_branch_load();
      cycle();
      clear_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL mid_stall_reset_hazard got %b want 0", hazard);
      end
      cycle();
      reset = 1'b0;
      #1;
      checks++;
      if (stallCount !== 32'd0) begin
         errors++; $display("FAIL mid_stall_reset_count got %h want 0", stallCount);
      end
      checks++;
      if (hazard !== 1'b0) begin
         errors++; $display("FAIL mid_stall_post_idle got %b want 0", hazard);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.stall_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_count_q;
      m_count = 64'h0000_0000_FFFF_FFFE;
      set_load_use();
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (stallCount !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL saturate_%0d got %h want ffffffff", i, stallCount);
         end
      end
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         addressRsId = 5'($urandom_range(0, 3));
         addressRtId = 5'($urandom_range(0, 3));
         addressRsEx = 5'($urandom_range(0, 3));
         addressRtEx = 5'($urandom_range(0, 3));
         branchId = 1'($urandom_range(0, 1));
         memReadEx = 1'($urandom_range(0, 1));
         regWriteEx = 1'($urandom_range(0, 1));
         memReadMemInput = 1'($urandom_range(0, 1));
         regWriteMemInput = 1'($urandom_range(0, 1));
         regWriteWbInput = 1'($urandom_range(0, 1));
         regWriteRegisterEx = 5'($urandom_range(0, 3));
         regWriteRegisterMemInput = 5'($urandom_range(0, 3));
         regWriteAddressWbInput = 5'($urandom_range(0, 3));
         #1;
         checks++;
         if (hazard !== exp_hazard()) begin
            errors++; $display("FAIL rand_hazard[%0d] got %b want %b", n, hazard, exp_hazard());
         end
         checks++;
         if (forwardingMux0Ex !== calc_fwd(addressRsEx)) begin
            errors++;
            $display("FAIL rand_fwd0[%0d] got %b want %b", n, forwardingMux0Ex,
                     calc_fwd(addressRsEx));
         end
         checks++;
         if (forwardingMux1Ex !== calc_fwd(addressRtEx)) begin
            errors++;
            $display("FAIL rand_fwd1[%0d] got %b want %b", n, forwardingMux1Ex,
                     calc_fwd(addressRtEx));
         end
         cycle();
         checks++;
         if (stallCount !== m_count[31:0]) begin
            errors++; $display("FAIL rand_count[%0d] got %h want %h", n, stallCount, m_count[31:0]);
         end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      m_pending = 0;
      m_count   = 0;
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      cycle();
      test_reset();
      test_load_use();
      test_branch_load();
      test_forward_priority();
      test_zero_reg();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
